// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard encoder.
//   BYTE_W / SEQ_W / KEY_W : byte, sequence and event-word widths
//   PS2_EXT / PS2_BRK / PS2_PAUSE : prefix byte codes
//   is_drop()   : keyboard response codes ignored at the start of a sequence
//   is_prefix() : bytes that never end a sequence by themselves
package ps2_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEQ_W  = 64;
    localparam int unsigned KEY_W  = 65;

    localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] PS2_BRK   = 8'hF0;
    localparam logic [BYTE_W-1:0] PS2_PAUSE = 8'hE1;

    // PRNSCR make/break hold points (the sequence continues past these)
    localparam logic [15:0] PRNSCR_HOLD_MK = 16'hE012;
    localparam logic [23:0] PRNSCR_HOLD_BR = 24'hE0F07C;

    // ACK, BAT pass, echo, resend, error and buffer-overrun responses
    function automatic logic is_drop(input logic [BYTE_W-1:0] b);
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFF, 8'h00: is_drop = 1'b1;
            default:                                  is_drop = 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [BYTE_W-1:0] b);
        is_prefix = (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial deframer: synchronizers, clock glitch filter, frame FSM and
// inter-bit timeout.
//   clk_sys, rst        : system clock, async active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 lines
//   data_byte, valid    : received byte, one-cycle strobe
//   err                 : one-cycle pulse on start/parity/stop/timeout error
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER      = 8,
    parameter int unsigned BIT_TIMEOUT = 2400
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] data_byte,
    output logic              valid,
    output logic              err
);

    localparam int unsigned FILT_W = $clog2(FILTER + 1);
    localparam int unsigned TO_W   = $clog2(BIT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic [1:0]        clk_sync, dat_sync;
    logic              clk_last;
    logic [FILT_W-1:0] stable_cnt, stable_nxt;
    logic              armed;
    logic              fall_ok;

    rx_state_t         state, state_nxt;
    logic [BYTE_W-1:0] shreg, shreg_nxt, byte_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic              par_bit, par_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              valid_nxt, err_nxt;

    // Count of consecutive cycles the synchronized clock has held its level
    always_comb begin
        if (clk_sync[1] != clk_last) begin
            stable_nxt = FILT_W'(1);
        end else if (stable_cnt != FILT_W'(FILTER)) begin
            stable_nxt = stable_cnt + FILT_W'(1);
        end else begin
            stable_nxt = stable_cnt;
        end
        // armed only after a long-enough high; short lows never reach FILTER
        fall_ok = armed && !clk_sync[1] && (stable_nxt == FILT_W'(FILTER));
    end

    // Synchronizers and glitch filter; lines idle high
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_last   <= 1'b1;
            stable_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            clk_last   <= clk_sync[1];
            stable_cnt <= stable_nxt;
            if (fall_ok) begin
                armed <= 1'b0;
            end else if (clk_sync[1] && (stable_nxt == FILT_W'(FILTER))) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM next state
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_bit;
        byte_nxt    = data_byte;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        to_nxt      = (state == IDLE || fall_ok) ? '0 : to_cnt + TO_W'(1);

        case (state)
            IDLE: begin
                if (fall_ok) begin
                    if (!dat_sync[1]) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_ok) begin
                    shreg_nxt = {dat_sync[1], shreg[BYTE_W-1:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall_ok) begin
                    par_nxt   = dat_sync[1];
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (fall_ok) begin
                    state_nxt = IDLE;
                    // odd parity: data plus parity bit has an odd number of ones
                    if (dat_sync[1] && (^{shreg, par_bit})) begin
                        valid_nxt = 1'b1;
                        byte_nxt  = shreg;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE && !fall_ok && to_cnt == TO_W'(BIT_TIMEOUT - 1)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            to_nxt    = '0;
        end
    end

    // Frame FSM registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            data_byte <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            par_bit   <= par_nxt;
            to_cnt    <= to_nxt;
            data_byte <= byte_nxt;
            valid     <= valid_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// Builds the 65-bit ps2_key event word from a raw PS/2 keyboard.
//   clk_sys, RESET     : system clock, async active-high reset
//   ps2_clk, ps2_data  : raw PS/2 lines
//   ps2_key            : [64] toggles per event, [63:0] byte sequence, oldest highest
//   rx_err             : one-cycle pulse on a deframer error
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER      = 8,
    parameter int unsigned BIT_TIMEOUT = 2400,
    parameter int unsigned SEQ_TIMEOUT = 240000
) (
    input  logic             clk_sys,
    input  logic             RESET,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KEY_W-1:0] ps2_key,
    output logic             rx_err
);

    // An 8th byte always completes, so only seven bytes are ever held
    localparam int unsigned SR_W  = SEQ_W - BYTE_W;
    localparam int unsigned TMR_W = $clog2(SEQ_TIMEOUT + 1);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;

    logic [SR_W-1:0]   sr;
    logic [SEQ_W-1:0]  sr_shift;
    logic [3:0]        n, n_inc;
    logic              pause, pause_nxt;
    logic [TMR_W-1:0]  seq_cnt;
    logic              take, held, complete, seq_expire;

    ps2_rx #(
        .FILTER      (FILTER),
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_rx (
        .clk_sys   (clk_sys),
        .rst       (RESET),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_byte (rx_byte),
        .valid     (rx_valid),
        .err       (rx_err)
    );

    // Sequence assembly decisions for the incoming byte
    always_comb begin
        sr_shift   = {sr, rx_byte};
        n_inc      = n + 4'd1;
        take       = rx_valid && !((n == 4'd0) && is_drop(rx_byte));
        pause_nxt  = pause || ((n == 4'd0) && (rx_byte == PS2_PAUSE));
        held       = ((n_inc == 4'd2) && (sr_shift[15:0] == PRNSCR_HOLD_MK)) ||
                     ((n_inc == 4'd3) && (sr_shift[23:0] == PRNSCR_HOLD_BR));
        complete   = (pause && (n_inc == 4'd8)) ||
                     (!pause && !is_prefix(rx_byte) && !held) ||
                     (n_inc == 4'd8);
        // an arriving byte always beats the timeout
        seq_expire = (n != 4'd0) && !rx_valid &&
                     (seq_cnt == TMR_W'(SEQ_TIMEOUT - 1));
    end

    // Assembler state, timeout counter and event word
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sr      <= '0;
            n       <= '0;
            pause   <= 1'b0;
            seq_cnt <= '0;
            ps2_key <= '0;
        end else begin
            if (rx_valid || (n == 4'd0) || seq_expire) begin
                seq_cnt <= '0;
            end else begin
                seq_cnt <= seq_cnt + TMR_W'(1);
            end

            if (take) begin
                if (complete) begin
                    ps2_key <= {~ps2_key[KEY_W-1], sr_shift};
                    sr      <= '0;
                    n       <= '0;
                    pause   <= 1'b0;
                end else begin
                    sr      <= sr_shift[SR_W-1:0];
                    n       <= n_inc;
                    pause   <= pause_nxt;
                end
            end else if (seq_expire) begin
                sr    <= '0;
                n     <= '0;
                pause <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: directed PS/2 frames, expected
// event words queued by the stimulus, checked by a monitor on each toggle.
module tb_ps2_key_encoder;

    localparam int unsigned FILTER      = 8;
    localparam int unsigned BIT_TIMEOUT = 200;
    localparam int unsigned SEQ_TIMEOUT = 2000;
    localparam int          HALF        = 20;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [64:0] ps2_key;
    logic        rx_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp  = 0;
    logic last_tog = 1'b0;
    logic [63:0] exp_q[$];

    ps2_key_encoder #(
        .FILTER      (FILTER),
        .BIT_TIMEOUT (BIT_TIMEOUT),
        .SEQ_TIMEOUT (SEQ_TIMEOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .rx_err   (rx_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: every toggle of bit 64 must match the oldest queued word
    always @(negedge clk_sys) begin
        if (!RESET) begin
            if (rx_err) err_seen++;
            if (ps2_key[64] !== last_tog) begin
                last_tog = ps2_key[64];
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got=%h required=none", ps2_key[63:0]);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (ps2_key[63:0] !== e) begin
                        errors++;
                        $display("FAIL event got=%h required=%h", ps2_key[63:0], e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Drive nbits frame bits LSB first, data set while the clock is high
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11);
    endtask

    task automatic send_seq(input logic [63:0] s, input int nb);
        for (int i = nb - 1; i >= 0; i--) send_byte(s[8*i +: 8], 1'b0);
    endtask

    // Let pending events land, then require the queue empty and errors matched
    task automatic drain(input string name);
        repeat (100) @(negedge clk_sys);
        check({name, "_pending"}, 65'(exp_q.size()), 65'd0);
        check({name, "_rx_err"}, 65'(err_seen), 65'(err_exp));
    endtask

    initial begin
        repeat (5) @(negedge clk_sys);
        check("reset_key", ps2_key, 65'd0);
        check("reset_err", {64'd0, rx_err}, 65'd0);
        RESET = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("post_reset_key", ps2_key, 65'd0);

        // single make / break
        exp_q.push_back(64'h1C);
        send_byte(8'h1C, 1'b0);
        repeat (5) @(negedge clk_sys);
        check("make_toggle", {64'd0, ps2_key[64]}, 65'd1);
        exp_q.push_back(64'hF01C);
        send_seq(64'hF01C, 2);
        repeat (5) @(negedge clk_sys);
        check("break_toggle", {64'd0, ps2_key[64]}, 65'd0);
        drain("make_break");

        // extended key
        exp_q.push_back(64'hE075);
        send_seq(64'hE075, 2);
        exp_q.push_back(64'hE0F075);
        send_seq(64'hE0F075, 3);
        drain("extended");

        // PRNSCR and PAUSE
        exp_q.push_back(64'hE012E07C);
        send_seq(64'hE012E07C, 4);
        exp_q.push_back(64'hE11477E1F014F077);
        send_seq(64'hE11477E1F014F077, 8);
        drain("prnscr_pause");

        // parity error then good byte
        err_exp++;
        send_byte(8'h1C, 1'b1);
        drain("parity_err");
        exp_q.push_back(64'h1C);
        send_byte(8'h1C, 1'b0);
        drain("after_parity");

        // sequence timeout drops the pending E0
        send_byte(8'hE0, 1'b0);
        repeat (SEQ_TIMEOUT + 1) @(negedge clk_sys);
        exp_q.push_back(64'h1C);
        send_byte(8'h1C, 1'b0);
        drain("seq_timeout");

        // truncated frame: start bit plus three data bits of 1C
        begin
            logic [10:0] part;
            part = {2'b11, 8'h1C, 1'b0};
            send_bits(part, 4);
        end
        repeat (BIT_TIMEOUT + 20) @(negedge clk_sys);
        err_exp++;
        exp_q.push_back(64'h5A);
        send_byte(8'h5A, 1'b0);
        drain("bit_timeout");

        // drop list: AA must not enter the sequence
        send_byte(8'hAA, 1'b0);
        exp_q.push_back(64'h29);
        send_byte(8'h29, 1'b0);
        drain("drop_list");

        // 3-cycle clock glitch is ignored
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk_sys);
        exp_q.push_back(64'h16);
        send_byte(8'h16, 1'b0);
        drain("glitch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
